fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
//  Holds PCF and talks to a variable-latency instruction memory (req/ready).
//  Feeds InstrD/PCPlus4D/ValidD to decode, which drives the hazard unit.
//  Obeys StallF/StallD from the hazard unit and PCSrcD/PCBranchD from decode.
//  Inserts bubbles when memory is slow or a branch redirects fetch.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PCF value after reset
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst_n      in   1   reset, asynchronous assert, active-low
//  StallF     in   1   hold PC / fetch (hazard unit)
//  StallD     in   1   hold IF/ID (hazard unit); driven equal to StallF
//  PCSrcD     in   1   taken branch resolved in decode
//  PCBranchD  in   32  branch target
//  ImemReq    out  1   instruction read request
//  ImemAddr   out  32  read address (= PCF)
//  ImemReady  in   1   transfer completes this cycle; ImemRdata valid
//  ImemRdata  in   32  instruction word
//  PCF        out  32  current fetch PC
//  InstrD     out  32  IF/ID instruction (0 = bubble)
//  PCPlus4D   out  32  IF/ID PC+4
//  ValidD     out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (rst_n=0, async): PCF=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0,
//   state=FETCH, buffer cleared. ImemReq forced 0 while rst_n=0.
//   Mid-transfer reset abandons the request; imem is reset with the core.
//  go = !StallF && !StallD.  redir = PCSrcD && ValidD && !StallD.
//  PCSrcD/PCBranchD are ignored unless ValidD=1 and StallD=0.
//  done = ImemReq && ImemReady. ImemReq=1 in FETCH and DRAIN, 0 in BUF.
//  ImemAddr=PCF. While ImemReq=1 and !ImemReady, PCF/ImemAddr must not
//   change; no request is ever withdrawn.
//  States (2-bit):
//  FETCH:
//   - redir & !done: RedirPC<=PCBranchD; ->DRAIN; IF/ID<=bubble.
//   - redir & done:  discard data; PCF<=PCBranchD; stay; IF/ID<=bubble.
//   - done & go: InstrD<=ImemRdata, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4.
//   - done & !go: Buf<=ImemRdata; ->BUF; IF/ID holds.
//   - !done & !StallD: IF/ID<=bubble. !done & StallD: IF/ID holds.
//  BUF (instruction parked, no request):
//   - redir: discard Buf; PCF<=PCBranchD; ->FETCH; IF/ID<=bubble.
//   - go: IF/ID<=Buf, PCF+4, ValidD=1; PCF<=PCF+4; ->FETCH.
//   - else hold everything.
//  DRAIN (wrong-path request outstanding):
//   - done: discard data; PCF<=RedirPC; ->FETCH.
//   - IF/ID loads bubble whenever !StallD.
//   - redir cannot occur (ValidD=0 after first bubble).
//  Bubble: InstrD=0, ValidD=0, PCPlus4D=0. Redirect overrides StallF on PC.
//  PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
//  Zero-wait memory (ImemReady=1 constantly): one instr/cycle, no bubbles.
// TESTING
//  1. Reset, ImemReady=1 always -> ImemAddr 0,4,8,...; InstrD follows
//     ImemRdata one cycle later; ValidD=1 from 2nd cycle.
//  2. ImemReady low 3 cycles at PC 0x10 -> ImemAddr stays 0x10; 3 bubbles
//     (ValidD=0); then InstrD=word@0x10, PCPlus4D=0x14.
//  3. ImemReady=1 with StallF=StallD=1 for 2 cycles -> state BUF, ImemReq=0,
//     IF/ID held; on release InstrD=buffered word, PCF advances by 4.
//  4. PCSrcD=1, PCBranchD=0x100 while ImemReady=0 -> DRAIN; old word
//     discarded on ready; next ImemAddr=0x100; ValidD=0 until word@0x100.
//  5. PCSrcD=1 with ValidD=0 or StallD=1 -> ignored; PCF unchanged.
//  6. rst_n low mid-wait at PC 0x40 -> PCF=RESET_PC, ValidD=0, ImemReq=0
//     immediately; fetch restarts at RESET_PC after rst_n rises.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Fetch stage and IF/ID pipeline register of a 5-stage MIPS core.
//   This module holds the fetch PC (PCF) and reads instructions from an
//   instruction memory whose latency varies (ImemReq/ImemReady).
//   It feeds InstrD/PCPlus4D/ValidD to decode. It obeys StallF/StallD from
//   the hazard unit and applies taken-branch redirects from decode.
//
// Handshake: ImemReq/ImemAddr form a request. A transfer completes on a
//   rising edge where ImemReq && ImemReady, and ImemRdata is valid in that
//   same cycle. Once ImemReq is raised it stays high, and ImemAddr stays
//   stable, until the transfer completes. A request is never withdrawn.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   StallF, StallD       hazard-unit stalls (driven equal)
//   PCSrcD, PCBranchD    taken branch and its target from decode
//   ImemReq, ImemAddr    instruction read request / address (= PCF)
//   ImemReady, ImemRdata transfer completion / instruction word
//   PCF                  current fetch PC
//   InstrD, PCPlus4D     IF/ID register (InstrD = 0 for a bubble)
//   ValidD               IF/ID holds a real instruction
//   state_dbg            FSM state: 0 = FETCH, 1 = BUF, 2 = DRAIN
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemRdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding for PCF
        BUF   = 2'd1,   // word for PCF parked in buf_q, no request
        DRAIN = 2'd2    // wrong-path request outstanding, target in redir_pc
    } state_t;

    state_t      state;
    logic [31:0] buf_q;
    logic [31:0] redir_pc;

    logic        go;
    logic        redir;
    logic        done;
    logic [31:0] pc_plus4;

    // ImemReq is gated by rst_n so that it drops as soon as reset asserts.
    // It does not wait for the registers to clear.
    assign ImemReq   = rst_n && (state != BUF);
    assign ImemAddr  = PCF;
    assign state_dbg = state;

    assign go       = !StallF && !StallD;
    assign redir    = PCSrcD && ValidD && !StallD;
    assign done     = ImemReq && ImemReady;
    assign pc_plus4 = PCF + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            PCF      <= RESET_PC;
            InstrD   <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
            buf_q    <= 32'd0;
            redir_pc <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (redir && !done) begin
                        // The request cannot be withdrawn. Keep the target
                        // until the wrong-path word arrives.
                        redir_pc <= PCBranchD;
                        state    <= DRAIN;
                        InstrD   <= 32'd0;
                        PCPlus4D <= 32'd0;
                        ValidD   <= 1'b0;
                    end else if (redir && done) begin
                        PCF      <= PCBranchD;
                        InstrD   <= 32'd0;
                        PCPlus4D <= 32'd0;
                        ValidD   <= 1'b0;
                    end else if (done && go) begin
                        InstrD   <= ImemRdata;
                        PCPlus4D <= pc_plus4;
                        ValidD   <= 1'b1;
                        PCF      <= pc_plus4;
                    end else if (done) begin
                        // Decode is stalled, so park the word.
                        buf_q <= ImemRdata;
                        state <= BUF;
                    end else if (!StallD) begin
                        InstrD   <= 32'd0;
                        PCPlus4D <= 32'd0;
                        ValidD   <= 1'b0;
                    end
                end

                BUF: begin
                    if (redir) begin
                        PCF      <= PCBranchD;
                        state    <= FETCH;
                        InstrD   <= 32'd0;
                        PCPlus4D <= 32'd0;
                        ValidD   <= 1'b0;
                    end else if (go) begin
                        InstrD   <= buf_q;
                        PCPlus4D <= pc_plus4;
                        ValidD   <= 1'b1;
                        PCF      <= pc_plus4;
                        state    <= FETCH;
                    end
                end

                DRAIN: begin
                    if (done) begin
                        PCF   <= redir_pc;
                        state <= FETCH;
                    end
                    if (!StallD) begin
                        InstrD   <= 32'd0;
                        PCPlus4D <= 32'd0;
                        ValidD   <= 1'b0;
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Testbench for fetch_stage. It runs directed scenarios, then randomized
//   traffic checked against a transaction-level reference model.
//   The instruction memory is a pure function of the address.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, PCSrcD = 1'b0, ImemReady = 1'b0;
    logic [31:0] PCBranchD = 32'd0;
    logic        ImemReq, ValidD;
    logic [31:0] ImemAddr, ImemRdata, PCF, InstrD, PCPlus4D;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    localparam logic [1:0] ST_FETCH = 2'd0, ST_BUF = 2'd1, ST_DRAIN = 2'd2;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    // Memory data is only meaningful on a ready cycle.
    assign ImemRdata = ImemReady ? mem_word(ImemAddr) : 32'hDEAD_BEEF;

    fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .ImemReq(ImemReq),
        .ImemAddr(ImemAddr), .ImemReady(ImemReady), .ImemRdata(ImemRdata),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .state_dbg(state_dbg)
    );

    // ---------------- reference model ----------------
    // Fetch is viewed as: a PC to fetch, an optional parked word, an optional
    // pending wrong-path transfer with its real target, and the decode slot.
    logic [31:0] m_pc, m_park_word, m_target, m_instr, m_pcp4;
    logic        m_parked, m_draining, m_valid, m_req;

    task automatic model_reset();
        m_pc = 32'h0; m_park_word = 32'h0; m_target = 32'h0;
        m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
        m_parked = 1'b0; m_draining = 1'b0; m_req = 1'b1;
    endtask

    task automatic model_step(input logic stall, input logic src,
                              input logic [31:0] tgt, input logic rdy);
        logic arrived, take_branch, slot_free;
        logic [31:0] word;
        arrived     = !m_parked && rdy;
        slot_free   = !stall;
        take_branch = src && m_valid && !stall;
        word        = m_parked ? m_park_word : mem_word(m_pc);
        if (m_draining) begin
            if (arrived) begin m_pc = m_target; m_draining = 1'b0; end
            if (slot_free) begin m_instr = 0; m_pcp4 = 0; m_valid = 0; end
        end else if (take_branch) begin
            m_instr = 0; m_pcp4 = 0; m_valid = 0;
            if (m_parked || arrived) m_pc = tgt;
            else begin m_draining = 1'b1; m_target = tgt; end
            m_parked = 1'b0;
        end else if ((m_parked || arrived) && slot_free) begin
            m_instr = word; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_parked = 1'b0;
        end else if (arrived) begin
            m_parked = 1'b1; m_park_word = word;
        end else if (!m_parked && slot_free) begin
            m_instr = 0; m_pcp4 = 0; m_valid = 0;
        end
        m_req = !m_parked;
    endtask

    // ---------------- driver tasks ----------------
    logic        pre_req;
    logic [31:0] pre_addr;
    logic        exp_pre_req;
    logic [31:0] exp_pre_addr;

    // Drive one cycle. The request seen before the edge goes to pre_*.
    // The model's view goes to exp_pre_*. Returns #1 after the rising edge.
    task automatic cycle(input logic stall, input logic src,
                         input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        StallF = stall; StallD = stall; PCSrcD = src; PCBranchD = tgt;
        ImemReady = rdy;
        #1;
        pre_req = ImemReq; pre_addr = ImemAddr;
        exp_pre_req = m_req; exp_pre_addr = m_pc;
        model_step(stall, src, tgt, rdy);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; StallF = 0; StallD = 0; PCSrcD = 0; ImemReady = 0;
        PCBranchD = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; ImemReady = 1'b1;
        #1;
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ImemReq); end
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf: got %h want 0", PCF); end
        checks++; if (InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_ifid: got %h/%h want 0/0", InstrD, PCPlus4D); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ValidD); end
        checks++; if (state_dbg !== ST_FETCH) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_FETCH); end
        do_reset();
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 0, 1);
            checks++; if (pre_addr !== 32'(4*k) || pre_req !== 1'b1) begin errors++; $display("FAIL zw_addr%0d: got %h req %b want %h req 1", k, pre_addr, pre_req, 4*k); end
            checks++; if (InstrD !== mem_word(32'(4*k)) || PCPlus4D !== 32'(4*k+4) || ValidD !== 1'b1) begin errors++; $display("FAIL zw_ifid%0d: got %h %h %b want %h %h 1", k, InstrD, PCPlus4D, ValidD, mem_word(32'(4*k)), 4*k+4); end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        repeat (4) cycle(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0);
            checks++; if (ImemAddr !== 32'h10 || ImemReq !== 1'b1) begin errors++; $display("FAIL ws_addr%0d: got %h req %b want 10 req 1", k, ImemAddr, ImemReq); end
            checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin errors++; $display("FAIL ws_bubble%0d: got %b %h want 0 0", k, ValidD, InstrD); end
        end
        cycle(0, 0, 0, 1);
        checks++; if (InstrD !== mem_word(32'h10) || PCPlus4D !== 32'h14 || ValidD !== 1'b1) begin errors++; $display("FAIL ws_deliver: got %h %h %b want %h 14 1", InstrD, PCPlus4D, ValidD, mem_word(32'h10)); end
    endtask

    task automatic test_stall_buffer();
        do_reset();
        repeat (2) cycle(0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            cycle(1, 0, 0, 1);
            checks++; if (state_dbg !== ST_BUF || ImemReq !== 1'b0) begin errors++; $display("FAIL st_buf%0d: got state %0d req %b want %0d req 0", k, state_dbg, ImemReq, ST_BUF); end
            checks++; if (InstrD !== mem_word(32'h4) || PCPlus4D !== 32'h8 || ValidD !== 1'b1 || PCF !== 32'h8) begin errors++; $display("FAIL st_hold%0d: got %h %h %b pc %h want %h 8 1 pc 8", k, InstrD, PCPlus4D, ValidD, PCF, mem_word(32'h4)); end
        end
        cycle(0, 0, 0, 0);
        checks++; if (InstrD !== mem_word(32'h8) || PCPlus4D !== 32'hC || PCF !== 32'hC || state_dbg !== ST_FETCH) begin errors++; $display("FAIL st_release: got %h %h pc %h st %0d want %h C pc C st 0", InstrD, PCPlus4D, PCF, state_dbg, mem_word(32'h8)); end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        repeat (2) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h100, 0);
        checks++; if (state_dbg !== ST_DRAIN || ValidD !== 1'b0 || PCF !== 32'h8) begin errors++; $display("FAIL rd_enter: got st %0d v %b pc %h want %0d 0 8", state_dbg, ValidD, PCF, ST_DRAIN); end
        cycle(0, 0, 0, 0);
        checks++; if (pre_addr !== 32'h8 || ValidD !== 1'b0) begin errors++; $display("FAIL rd_wait: got addr %h v %b want 8 0", pre_addr, ValidD); end
        cycle(0, 0, 0, 1);
        checks++; if (PCF !== 32'h100 || ValidD !== 1'b0 || state_dbg !== ST_FETCH) begin errors++; $display("FAIL rd_discard: got pc %h v %b st %0d want 100 0 0", PCF, ValidD, state_dbg); end
        cycle(0, 0, 0, 1);
        checks++; if (pre_addr !== 32'h100 || InstrD !== mem_word(32'h100) || PCPlus4D !== 32'h104 || ValidD !== 1'b1) begin errors++; $display("FAIL rd_target: got addr %h %h %h %b want 100 %h 104 1", pre_addr, InstrD, PCPlus4D, ValidD, mem_word(32'h100)); end
    endtask

    task automatic test_redirect_ignored();
        do_reset();
        cycle(0, 1, 32'h200, 1);   // ValidD is still 0 here
        checks++; if (PCF !== 32'h4 || ValidD !== 1'b1) begin errors++; $display("FAIL ign_invalid: got pc %h v %b want 4 1", PCF, ValidD); end
        cycle(1, 1, 32'h200, 1);   // stalled
        checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL ign_stall: got pc %h want 4", PCF); end
        cycle(0, 0, 0, 0);
        checks++; if (PCF !== 32'h8 || InstrD !== mem_word(32'h4)) begin errors++; $display("FAIL ign_resume: got pc %h %h want 8 %h", PCF, InstrD, mem_word(32'h4)); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 1, 32'hFFFF_FFFC, 1);
        checks++; if (PCF !== 32'hFFFF_FFFC || ValidD !== 1'b0) begin errors++; $display("FAIL wrap_redir: got pc %h v %b want FFFFFFFC 0", PCF, ValidD); end
        cycle(0, 0, 0, 1);
        checks++; if (PCF !== 32'h0 || PCPlus4D !== 32'h0 || InstrD !== mem_word(32'hFFFF_FFFC) || ValidD !== 1'b1) begin errors++; $display("FAIL wrap_pc: got pc %h p4 %h %h want 0 0 %h", PCF, PCPlus4D, InstrD, mem_word(32'hFFFF_FFFC)); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        repeat (16) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        checks++; if (PCF !== 32'h40 || ImemReq !== 1'b1) begin errors++; $display("FAIL mr_wait: got pc %h req %b want 40 1", PCF, ImemReq); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (PCF !== 32'h0 || ValidD !== 1'b0 || ImemReq !== 1'b0) begin errors++; $display("FAIL mr_async: got pc %h v %b req %b want 0 0 0", PCF, ValidD, ImemReq); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(0, 0, 0, 1);
        checks++; if (pre_addr !== 32'h0 || InstrD !== mem_word(32'h0) || PCF !== 32'h4) begin errors++; $display("FAIL mr_restart: got addr %h %h pc %h want 0 %h 4", pre_addr, InstrD, PCF, mem_word(32'h0)); end
    endtask

    task automatic test_random();
        logic        st, src, rdy;
        logic [31:0] tgt;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            st  = ($urandom_range(0, 3) == 0);
            src = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8
                                               : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            cycle(st, src, tgt, rdy);
            checks++; if (pre_req !== exp_pre_req || pre_addr !== exp_pre_addr) begin errors++; $display("FAIL rnd_req@%0d: got %b %h want %b %h", n, pre_req, pre_addr, exp_pre_req, exp_pre_addr); end
            checks++; if (PCF !== m_pc) begin errors++; $display("FAIL rnd_pcf@%0d: got %h want %h", n, PCF, m_pc); end
            checks++; if (InstrD !== m_instr || PCPlus4D !== m_pcp4 || ValidD !== m_valid) begin errors++; $display("FAIL rnd_ifid@%0d: got %h %h %b want %h %h %b", n, InstrD, PCPlus4D, ValidD, m_instr, m_pcp4, m_valid); end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        model_reset();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_buffer();
        test_redirect_drain();
        test_redirect_ignored();
        test_pc_wrap();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
